// File: rtl/dram_arb_pkg.sv
// Shared definitions for the DRAM port arbiter: data/address widths and the
// owner encoding used for both the arbitration result and the executing cycle.
package dram_arb_pkg;

   localparam int DRAM_AW = 21;
   localparam int DRAM_DW = 16;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_VID  = 2'd1,
      OWN_CPU  = 2'd2,
      OWN_DMA  = 2'd3
   } owner_e;

endpackage

// File: rtl/dram_arb_if.sv
// Requester and DRAM controller bus of the arbiter.
// Handshake: each requester holds X_req (level) with its address/data; X_next
// pulses for one clk on the cycle the request is accepted, after which the
// requester may change or drop its inputs. For reads, X_rdy pulses for one clk
// when rddata holds the word. The controller side (req/addr/rnw/wrdata/bsel)
// is stable from c3 of the arbitration cycle through c0 of the executed cycle.
// The arbiter uses the slave modport; the requesters/controller model uses master.
interface dram_arb_if;
   import dram_arb_pkg::*;

   logic               vid_req;
   logic [DRAM_AW-1:0] vid_addr;
   logic               vid_next;
   logic               vid_rdy;

   logic               cpu_req;
   logic [DRAM_AW-1:0] cpu_addr;
   logic               cpu_rnw;
   logic [DRAM_DW-1:0] cpu_wrdata;
   logic [1:0]         cpu_bsel;
   logic               cpu_next;
   logic               cpu_rdy;

   logic               dma_req;
   logic [DRAM_AW-1:0] dma_addr;
   logic               dma_rnw;
   logic [DRAM_DW-1:0] dma_wrdata;
   logic [1:0]         dma_bsel;
   logic               dma_next;
   logic               dma_rdy;

   logic [DRAM_DW-1:0] dram_rd;
   logic [DRAM_DW-1:0] rddata;

   logic               req;
   logic [DRAM_AW-1:0] addr;
   logic               rnw;
   logic [DRAM_DW-1:0] wrdata;
   logic [1:0]         bsel;

   modport slave (
      input  vid_req, vid_addr,
      input  cpu_req, cpu_addr, cpu_rnw, cpu_wrdata, cpu_bsel,
      input  dma_req, dma_addr, dma_rnw, dma_wrdata, dma_bsel,
      input  dram_rd,
      output vid_next, vid_rdy, cpu_next, cpu_rdy, dma_next, dma_rdy,
      output rddata, req, addr, rnw, wrdata, bsel
   );

   modport master (
      output vid_req, vid_addr,
      output cpu_req, cpu_addr, cpu_rnw, cpu_wrdata, cpu_bsel,
      output dma_req, dma_addr, dma_rnw, dma_wrdata, dma_bsel,
      output dram_rd,
      input  vid_next, vid_rdy, cpu_next, cpu_rdy, dma_next, dma_rdy,
      input  rddata, req, addr, rnw, wrdata, bsel
   );

endinterface

// File: rtl/dram_arb_pick.sv
// Combinational winner select. Video always wins; the CPU/DMA order comes
// from the starvation override (default build) or from the round-robin
// pointer when DRAM_ARB_RR_EN is defined.
module dram_arb_pick
   import dram_arb_pkg::*;
#(
   parameter int DMA_MAXWAIT = 4,
   parameter int WCNT_W      = 3
) (
   input  logic              vid_req,
   input  logic              cpu_req,
   input  logic              dma_req,
`ifdef DRAM_ARB_RR_EN
   input  logic              rr_ptr,   // 0: CPU next in line, 1: DMA next in line
`else
   input  logic [WCNT_W-1:0] wcnt,
`endif
   output owner_e            win
);

   logic dma_first;

`ifdef DRAM_ARB_RR_EN
   assign dma_first = rr_ptr;
`else
   localparam logic [WCNT_W-1:0] MAXW = WCNT_W'(DMA_MAXWAIT);
   assign dma_first = (wcnt >= MAXW);
`endif

   // Priority select: vid first, then cpu/dma in the order chosen above
   always_comb begin
      win = OWN_NONE;
      if (vid_req)
         win = OWN_VID;
      else if (cpu_req && dma_req)
         win = dma_first ? OWN_DMA : OWN_CPU;
      else if (cpu_req)
         win = OWN_CPU;
      else if (dma_req)
         win = OWN_DMA;
   end

endmodule

// File: rtl/dram_arb.sv
// DRAM port arbiter for video, CPU and DMA. Arbitrates at c2, drives the
// controller from c3 through c0 of the executed cycle, captures read data at
// c2 of that cycle and pulses the owner's rdy at the following c3.
// Optional build macro: DRAM_ARB_RR_EN (round-robin CPU/DMA sharing instead of
// fixed priority with DMA starvation override).
module dram_arb
   import dram_arb_pkg::*;
#(
   parameter int DMA_MAXWAIT = 4,   // must be < 2**WCNT_W
   parameter int WCNT_W      = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        c0,
   input  logic        c1,
   input  logic        c2,
   input  logic        c3,
   dram_arb_if.slave   bus
);

   owner_e win;        // combinational arbitration result
   owner_e pend_own;   // owner granted at the last c2
   owner_e exec_own;   // owner of the DRAM cycle now executing
   owner_e rdy_own;    // owner whose rdy pulses this clk
   logic   exec_rnw;
   logic   arb_en;

   // c0/c1 are consumed by the DRAM controller; the arbiter keys only on c2/c3
   logic unused_strobes;
   assign unused_strobes = c0 ^ c1;

   assign arb_en = c2 && !rst;

`ifdef DRAM_ARB_RR_EN
   logic rr_ptr;

   dram_arb_pick #(.DMA_MAXWAIT(DMA_MAXWAIT), .WCNT_W(WCNT_W)) u_pick (
      .vid_req (bus.vid_req),
      .cpu_req (bus.cpu_req),
      .dma_req (bus.dma_req),
      .rr_ptr  (rr_ptr),
      .win     (win)
   );

   // Round-robin pointer: after a CPU or DMA grant, point at the other agent
   always_ff @(posedge clk) begin
      if (rst)
         rr_ptr <= 1'b0;
      else if (c2 && (win == OWN_CPU || win == OWN_DMA))
         rr_ptr <= (win == OWN_CPU);
   end
`else
   logic [WCNT_W-1:0] wcnt;

   dram_arb_pick #(.DMA_MAXWAIT(DMA_MAXWAIT), .WCNT_W(WCNT_W)) u_pick (
      .vid_req (bus.vid_req),
      .cpu_req (bus.cpu_req),
      .dma_req (bus.dma_req),
      .wcnt    (wcnt),
      .win     (win)
   );

   // DMA wait counter: counts consecutive lost cycles, saturating
   always_ff @(posedge clk) begin
      if (rst)
         wcnt <= '0;
      else if (c2) begin
         if (bus.dma_req && win != OWN_DMA)
            wcnt <= (&wcnt) ? wcnt : wcnt + WCNT_W'(1);
         else
            wcnt <= '0;
      end
   end
`endif

   // Grant register: load the winner's command at c2, hold until the next c2
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.req    <= 1'b0;
         bus.addr   <= '0;
         bus.rnw    <= 1'b1;
         bus.wrdata <= '0;
         bus.bsel   <= '0;
         pend_own   <= OWN_NONE;
      end else if (c2) begin
         pend_own <= win;
         case (win)
            OWN_VID: begin
               bus.req  <= 1'b1;
               bus.addr <= bus.vid_addr;
               bus.rnw  <= 1'b1;
               bus.bsel <= 2'b11;
            end
            OWN_CPU: begin
               bus.req    <= 1'b1;
               bus.addr   <= bus.cpu_addr;
               bus.rnw    <= bus.cpu_rnw;
               bus.wrdata <= bus.cpu_wrdata;
               bus.bsel   <= bus.cpu_bsel;
            end
            OWN_DMA: begin
               bus.req    <= 1'b1;
               bus.addr   <= bus.dma_addr;
               bus.rnw    <= bus.dma_rnw;
               bus.wrdata <= bus.dma_wrdata;
               bus.bsel   <= bus.dma_bsel;
            end
            default: bus.req <= 1'b0;   // refresh cycle, command fields hold
         endcase
      end
   end

   // Executing-cycle register: the grant becomes the running cycle at c3
   always_ff @(posedge clk) begin
      if (rst) begin
         exec_own <= OWN_NONE;
         exec_rnw <= 1'b1;
      end else if (c3) begin
         exec_own <= pend_own;
         exec_rnw <= bus.rnw;
      end
   end

   // Read capture at c2 of the executing cycle; rdy owner set for one clk
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.rddata <= '0;
         rdy_own    <= OWN_NONE;
      end else begin
         rdy_own <= OWN_NONE;
         if (c2 && exec_own != OWN_NONE && exec_rnw) begin
            bus.rddata <= bus.dram_rd;
            rdy_own    <= exec_own;
         end
      end
   end

   assign bus.vid_next = arb_en && (win == OWN_VID);
   assign bus.cpu_next = arb_en && (win == OWN_CPU);
   assign bus.dma_next = arb_en && (win == OWN_DMA);

   assign bus.vid_rdy = (rdy_own == OWN_VID);
   assign bus.cpu_rdy = (rdy_own == OWN_CPU);
   assign bus.dma_rdy = (rdy_own == OWN_DMA);

endmodule
